// File: rtl/qa_capture_dump.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : qa_capture_dump
//  Purpose  : Registered sample passthrough with a command-driven capture
//             buffer that can be dumped as a header + data message stream.
//             Supports keep-first and circular (keep-newest) capture.
//  Revision : 1.0  initial release
// ============================================================================
module qa_capture_dump #(
    parameter int WIDTH     = 32,
    parameter int MWIDTH    = 1,
    parameter int MSG_WIDTH = 32,
    parameter int DEPTH     = 64,
    parameter int WRAP      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_nd,
    input  logic [MWIDTH-1:0]    in_m,
    input  logic [MSG_WIDTH-1:0] in_msg,
    input  logic                 in_msg_nd,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_nd,
    output logic [MWIDTH-1:0]    out_m,
    output logic [MSG_WIDTH-1:0] out_msg,
    output logic                 out_msg_nd,
    output logic                 error
);

    localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(DEPTH + 1);

    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_capture = 2'd1;
    localparam logic [1:0] c_st_hdr     = 2'd2;
    localparam logic [1:0] c_st_data    = 2'd3;

    localparam logic [1:0] c_cmd_clear = 2'b00;
    localparam logic [1:0] c_cmd_arm   = 2'b01;
    localparam logic [1:0] c_cmd_dump  = 2'b10;

    logic [1:0]          r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_count, w_count_nxt;
    logic [c_cnt_w-1:0]  r_left,  w_left_nxt;
    logic [c_addr_w-1:0] r_wptr,  w_wptr_nxt;
    logic [c_addr_w-1:0] r_rptr,  w_rptr_nxt;
    logic                w_wr_en;
    logic                w_error;
    logic [1:0]          w_cmd;

    logic [WIDTH-1:0]     r_buf [DEPTH];
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_nd;
    logic [MWIDTH-1:0]    r_out_m;
    logic                 r_error;
    logic [MSG_WIDTH-1:0] w_msg;
    logic                 w_msg_nd;

    // Only the two command bits of the message word carry meaning.
    logic w_unused_msg;
    assign w_unused_msg = ^in_msg[MSG_WIDTH-3:0];

    assign w_cmd = in_msg[MSG_WIDTH-1 -: 2];

    // Next-state, capture-pointer and error decode for the capture/dump FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_left_nxt  = r_left;
        w_wr_en     = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            c_st_idle, c_st_capture: begin
                // A sample arriving with a command is captured first, so a
                // same-cycle DUMP includes it in the count.
                if (r_state == c_st_capture && in_nd) begin
                    if (WRAP != 0 || r_count != c_full) begin
                        w_wr_en    = 1'b1;
                        w_wptr_nxt = r_wptr + 1'b1;
                        if (r_count != c_full) begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end else begin
                        w_error = 1'b1;
                    end
                end
                if (in_msg_nd) begin
                    case (w_cmd)
                        c_cmd_clear: begin
                            w_count_nxt = '0;
                            w_wptr_nxt  = '0;
                            w_state_nxt = c_st_idle;
                        end
                        c_cmd_arm: begin
                            w_count_nxt = '0;
                            w_wptr_nxt  = '0;
                            w_state_nxt = c_st_capture;
                        end
                        c_cmd_dump: begin
                            w_state_nxt = c_st_hdr;
                        end
                        default: begin
                            w_error = 1'b1;
                        end
                    endcase
                end
            end
            c_st_hdr: begin
                // In a full circular buffer the write pointer marks the oldest sample.
                w_rptr_nxt  = (WRAP != 0 && r_count == c_full) ? r_wptr : '0;
                w_left_nxt  = r_count;
                w_state_nxt = (r_count == '0) ? c_st_idle : c_st_data;
                if (in_msg_nd) begin
                    w_error = 1'b1;
                end
            end
            c_st_data: begin
                w_rptr_nxt = r_rptr + 1'b1;
                w_left_nxt = r_left - 1'b1;
                if (r_left == c_cnt_one) begin
                    w_state_nxt = c_st_idle;
                end
                if (in_msg_nd) begin
                    w_error = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Control state, pointers, passthrough and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_count    <= '0;
            r_left     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_out_data <= '0;
            r_out_nd   <= 1'b0;
            r_out_m    <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_left     <= w_left_nxt;
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_out_data <= in_data;
            r_out_nd   <= in_nd;
            r_out_m    <= in_m;
            r_error    <= w_error;
        end
    end

    // Capture buffer storage; contents are only meaningful up to count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_wptr] <= in_data;
        end
    end

    // Dump stream word is a direct decode of the FSM state; zero when idle.
    always_comb begin
        w_msg    = '0;
        w_msg_nd = 1'b0;
        if (r_state == c_st_hdr) begin
            w_msg    = {2'b01, (MSG_WIDTH-2)'(r_count)};
            w_msg_nd = 1'b1;
        end else if (r_state == c_st_data) begin
            w_msg    = {2'b10, (MSG_WIDTH-2)'(r_buf[r_rptr])};
            w_msg_nd = 1'b1;
        end
    end

    assign out_data   = r_out_data;
    assign out_nd     = r_out_nd;
    assign out_m      = r_out_m;
    assign out_msg    = w_msg;
    assign out_msg_nd = w_msg_nd;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_qa_capture_dump.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_qa_capture_dump
//  Purpose  : Scoreboard bench for qa_capture_dump. Three instances:
//             0 = DEPTH 64 keep-first, 1 = DEPTH 4 keep-first,
//             2 = DEPTH 4 circular.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qa_capture_dump;

    localparam int W  = 16;
    localparam int MW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [W-1:0]  in_data    [3];
    logic          in_nd      [3];
    logic [0:0]    in_m       [3];
    logic [MW-1:0] in_msg     [3];
    logic          in_msg_nd  [3];
    logic [W-1:0]  out_data   [3];
    logic          out_nd     [3];
    logic [0:0]    out_m      [3];
    logic [MW-1:0] out_msg    [3];
    logic          out_msg_nd [3];
    logic          err        [3];

    qa_capture_dump #(.WIDTH(W), .MWIDTH(1), .MSG_WIDTH(MW), .DEPTH(64), .WRAP(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_nd(in_nd[0]), .in_m(in_m[0]),
        .in_msg(in_msg[0]), .in_msg_nd(in_msg_nd[0]),
        .out_data(out_data[0]), .out_nd(out_nd[0]), .out_m(out_m[0]),
        .out_msg(out_msg[0]), .out_msg_nd(out_msg_nd[0]), .error(err[0]));

    qa_capture_dump #(.WIDTH(W), .MWIDTH(1), .MSG_WIDTH(MW), .DEPTH(4), .WRAP(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_nd(in_nd[1]), .in_m(in_m[1]),
        .in_msg(in_msg[1]), .in_msg_nd(in_msg_nd[1]),
        .out_data(out_data[1]), .out_nd(out_nd[1]), .out_m(out_m[1]),
        .out_msg(out_msg[1]), .out_msg_nd(out_msg_nd[1]), .error(err[1]));

    qa_capture_dump #(.WIDTH(W), .MWIDTH(1), .MSG_WIDTH(MW), .DEPTH(4), .WRAP(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[2]), .in_nd(in_nd[2]), .in_m(in_m[2]),
        .in_msg(in_msg[2]), .in_msg_nd(in_msg_nd[2]),
        .out_data(out_data[2]), .out_nd(out_nd[2]), .out_m(out_m[2]),
        .out_msg(out_msg[2]), .out_msg_nd(out_msg_nd[2]), .error(err[2]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          d;
        logic [31:0] w;
        int          at;
    } exp_t;

    exp_t mq[$];
    exp_t eq[$];

    function automatic void push_msg(input int d, input logic [31:0] w, input int at);
        exp_t e;
        e.d = d; e.w = w; e.at = at;
        mq.push_back(e);
    endfunction

    function automatic void push_err(input int d, input int at);
        exp_t e;
        e.d = d; e.w = 32'h1; e.at = at;
        eq.push_back(e);
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
        end
    endfunction

    // Monitor: pops expected dump words and error pulses as each DUT presents them.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (out_msg_nd[d]) begin
                    if (mq.size() == 0) begin
                        failures++;
                        $display("FAIL msg_unexpected: dut %0d cyc %0d got %h expected no word", d, cyc, out_msg[d]);
                    end else begin
                        e = mq.pop_front();
                        if (e.d != d || e.at != cyc || e.w !== out_msg[d]) begin
                            failures++;
                            $display("FAIL msg_word: dut %0d cyc %0d got %h expected dut %0d cyc %0d word %h",
                                     d, cyc, out_msg[d], e.d, e.at, e.w);
                        end
                    end
                end else if (out_msg[d] !== '0) begin
                    failures++;
                    $display("FAIL msg_idle_zero: dut %0d cyc %0d got %h expected 0", d, cyc, out_msg[d]);
                end
                if (err[d]) begin
                    checks++;
                    if (eq.size() == 0) begin
                        failures++;
                        $display("FAIL err_unexpected: dut %0d cyc %0d got pulse expected none", d, cyc);
                    end else begin
                        e = eq.pop_front();
                        if (e.d != d || e.at != cyc) begin
                            failures++;
                            $display("FAIL err_pulse: dut %0d cyc %0d got pulse expected dut %0d cyc %0d",
                                     d, cyc, e.d, e.at);
                        end
                    end
                end
            end
            while (mq.size() > 0 && mq[0].at < cyc) begin
                e = mq.pop_front();
                checks++; failures++;
                $display("FAIL msg_missing: dut %0d cyc %0d got nothing expected %h", e.d, e.at, e.w);
            end
            while (eq.size() > 0 && eq[0].at < cyc) begin
                e = eq.pop_front();
                checks++; failures++;
                $display("FAIL err_missing: dut %0d cyc %0d got nothing expected pulse", e.d, e.at);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        for (int d = 0; d < 3; d++) begin
            in_data[d]   = '0;
            in_nd[d]     = 1'b0;
            in_m[d]      = '0;
            in_msg[d]    = '0;
            in_msg_nd[d] = 1'b0;
        end
    endtask

    task automatic drive(input int d, input bit nd, input logic [15:0] data,
                         input bit mnd, input logic [1:0] cmd);
        in_nd[d]     = nd;
        in_data[d]   = data;
        in_msg_nd[d] = mnd;
        in_msg[d]    = {cmd, 30'h0};
        step();
        clr_in();
    endtask

    logic [15:0] ev [8];

    // Issue DUMP and expect header plus ev[0..n-1] on consecutive cycles.
    task automatic dump_chk(input int d, input int n);
        int k;
        k = cyc;
        push_msg(d, 32'h4000_0000 | 32'(n), k + 1);
        for (int i = 0; i < n; i++) push_msg(d, {16'h8000, ev[i]}, k + 2 + i);
        drive(d, 1'b0, 16'h0, 1'b1, 2'b10);
        repeat (n + 1) step();
    endtask

    initial begin
        int k;
        // Reset held while inputs are active: every output must stay 0.
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_data[d] = 16'hFFFF; in_nd[d] = 1'b1; in_m[d] = 1'b1;
            in_msg[d] = 32'h4000_0000; in_msg_nd[d] = 1'b1;
        end
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            chk("rst_out_data",   32'(out_data[d]),   32'h0);
            chk("rst_out_nd",     32'(out_nd[d]),     32'h0);
            chk("rst_out_m",      32'(out_m[d]),      32'h0);
            chk("rst_out_msg",    out_msg[d],         32'h0);
            chk("rst_out_msg_nd", 32'(out_msg_nd[d]), 32'h0);
            chk("rst_error",      32'(err[d]),        32'h0);
        end
        clr_in();
        step();
        rst_n = 1'b1;
        step();

        // Empty dump after reset: header only.
        dump_chk(0, 0);

        // Capture 5,6,7 and dump.
        drive(0, 1'b0, 16'h0, 1'b1, 2'b01);
        drive(0, 1'b1, 16'd5, 1'b0, 2'b00);
        drive(0, 1'b1, 16'd6, 1'b0, 2'b00);
        drive(0, 1'b1, 16'd7, 1'b0, 2'b00);
        ev[0] = 16'd5; ev[1] = 16'd6; ev[2] = 16'd7;
        dump_chk(0, 3);

        // ARM during the header cycle: error, dump continues unchanged.
        k = cyc;
        push_msg(0, 32'h4000_0003, k + 1);
        push_msg(0, 32'h8000_0005, k + 2);
        push_msg(0, 32'h8000_0006, k + 3);
        push_msg(0, 32'h8000_0007, k + 4);
        push_err(0, k + 2);
        drive(0, 1'b0, 16'h0, 1'b1, 2'b10);
        drive(0, 1'b0, 16'h0, 1'b1, 2'b01);
        repeat (3) step();

        // Reserved command in IDLE: error, buffer and count untouched.
        k = cyc;
        push_err(0, k + 1);
        drive(0, 1'b0, 16'h0, 1'b1, 2'b11);
        step();
        dump_chk(0, 3);

        // Sample together with DUMP is captured and counted.
        drive(0, 1'b0, 16'h0, 1'b1, 2'b01);
        k = cyc;
        push_msg(0, 32'h4000_0001, k + 1);
        push_msg(0, 32'h8000_0009, k + 2);
        drive(0, 1'b1, 16'd9, 1'b1, 2'b10);
        repeat (2) step();

        // Passthrough in IDLE, then empty dump after CLEAR.
        drive(0, 1'b0, 16'h0, 1'b1, 2'b00);
        in_data[0] = 16'h00A5; in_m[0] = 1'b1; in_nd[0] = 1'b1;
        step();
        chk("pass_data", 32'(out_data[0]), 32'h0000_00A5);
        chk("pass_m",    32'(out_m[0]),    32'h1);
        chk("pass_nd",   32'(out_nd[0]),   32'h1);
        clr_in();
        step();
        chk("pass_nd_drop", 32'(out_nd[0]), 32'h0);
        dump_chk(0, 0);

        // Asynchronous reset mid-dump abandons the stream immediately.
        drive(0, 1'b0, 16'h0, 1'b1, 2'b01);
        drive(0, 1'b1, 16'd1, 1'b0, 2'b00);
        drive(0, 1'b1, 16'd2, 1'b0, 2'b00);
        k = cyc;
        push_msg(0, 32'h4000_0002, k + 1);
        push_msg(0, 32'h8000_0001, k + 2);
        drive(0, 1'b0, 16'h0, 1'b1, 2'b10);
        step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_msg_nd", 32'(out_msg_nd[0]), 32'h0);
        chk("rst_mid_msg",    out_msg[0],         32'h0);
        step();
        rst_n = 1'b1;
        step();
        dump_chk(0, 0);

        // DEPTH 4 keep-first: samples 5 and 6 are dropped with errors.
        drive(1, 1'b0, 16'h0, 1'b1, 2'b01);
        k = cyc;
        push_err(1, k + 5);
        push_err(1, k + 6);
        for (int i = 1; i <= 6; i++) drive(1, 1'b1, 16'(i), 1'b0, 2'b00);
        ev[0] = 16'd1; ev[1] = 16'd2; ev[2] = 16'd3; ev[3] = 16'd4;
        dump_chk(1, 4);

        // DEPTH 4 circular: newest four kept, oldest first, no error.
        drive(2, 1'b0, 16'h0, 1'b1, 2'b01);
        for (int i = 1; i <= 6; i++) drive(2, 1'b1, 16'(i), 1'b0, 2'b00);
        ev[0] = 16'd3; ev[1] = 16'd4; ev[2] = 16'd5; ev[3] = 16'd6;
        dump_chk(2, 4);

        repeat (3) step();
        chk("msg_queue_empty", 32'(mq.size()), 32'h0);
        chk("err_queue_empty", 32'(eq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
